// File: rtl/multi_chan_clk_div.sv
// Multi-channel programmable clock divider with shadowed divisors and a global phase sync.
// Each channel produces a 50%-duty divided clock and a one-cycle tick every d enabled cycles.
module multi_chan_clk_div #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 10000000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  active [NUM_CH];
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [CNT_W-1:0]  last   [NUM_CH];
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] wrap;

    // A stored divisor of 0 counts like 1; an out-of-range wr_ch matches no channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            last[i]   = (active[i] == '0) ? '0 : active[i] - ONE;
            wr_hit[i] = wr_en && (int'(wr_ch) == i);
            wrap[i]   = ch_en[i] && (cnt[i] == last[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                active[i] <= DEF_DIV;
                shadow[i] <= DEF_DIV;
            end
            clk_out <= '0;
            tick    <= '0;
            pending <= '0;
        end else if (sync) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
                if (wr_hit[i]) begin
                    active[i] <= wr_data;
                    shadow[i] <= wr_data;
                end else begin
                    active[i] <= shadow[i];
                end
            end
            clk_out <= '0;
            tick    <= '0;
            pending <= '0;
        end else begin
            // The wrap consumes the old shadow; a same-edge write re-arms pending afterwards.
            for (int i = 0; i < NUM_CH; i++) begin
                tick[i] <= wrap[i];
                if (wrap[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= ~clk_out[i];
                    active[i]  <= shadow[i];
                    pending[i] <= 1'b0;
                end else if (ch_en[i]) begin
                    cnt[i] <= cnt[i] + ONE;
                end
                if (wr_hit[i]) begin
                    shadow[i]  <= wr_data;
                    pending[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_chan_clk_div.sv
// Self-checking bench for multi_chan_clk_div: directed scenarios plus random traffic,
// compared every cycle against a period-level reference model of each channel.
module tb_multi_chan_clk_div;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] ch_en = '0;
    logic [3:0] clk_out;
    logic [3:0] tick;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;

    // Reference model: enabled edges elapsed in the current period, divisor in use, queued divisor.
    int       m_elapsed [NUM_CH];
    int       m_div     [NUM_CH];
    int       m_next    [NUM_CH];
    logic [3:0] m_clk, m_tick, m_pend;

    multi_chan_clk_div #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_en(ch_en),
        .sync(sync),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_data(wr_data),
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input logic r, input logic s, input logic we,
                             input logic [1:0] wc, input logic [7:0] wd, input logic [3:0] en);
        int period;
        if (r) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_elapsed[i] = 0;
                m_div[i]     = DEFAULT_DIV;
                m_next[i]    = DEFAULT_DIV;
            end
            m_clk = '0; m_tick = '0; m_pend = '0;
        end else if (s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_elapsed[i] = 0;
                if (we && int'(wc) == i) begin
                    m_div[i]  = int'(wd);
                    m_next[i] = int'(wd);
                end else begin
                    m_div[i] = m_next[i];
                end
            end
            m_clk = '0; m_tick = '0; m_pend = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                period    = (m_div[i] == 0) ? 1 : m_div[i];
                m_tick[i] = 1'b0;
                if (en[i]) begin
                    m_elapsed[i]++;
                    if (m_elapsed[i] == period) begin
                        m_elapsed[i] = 0;
                        m_clk[i]     = ~m_clk[i];
                        m_tick[i]    = 1'b1;
                        m_div[i]     = m_next[i];
                        m_pend[i]    = 1'b0;
                    end
                end
                if (we && int'(wc) == i) begin
                    m_next[i] = int'(wd);
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic we,
                                 input logic [1:0] wc, input logic [7:0] wd, input logic [3:0] en);
        rst = r; sync = s; wr_en = we; wr_ch = wc; wr_data = wd; ch_en = en;
        @(posedge clk);
        modelStep(r, s, we, wc, wd, en);
        #1;
        checkOutput("model_clk_out", 32'(clk_out), 32'(m_clk));
        checkOutput("model_tick",    32'(tick),    32'(m_tick));
        checkOutput("model_pending", 32'(pending), 32'(m_pend));
    endtask

    initial begin
        int hits;
        int guard;

        applyStimulus(1, 0, 0, 0, 0, 4'h0);
        applyStimulus(1, 0, 0, 0, 0, 4'hF);
        checkOutput("reset_outputs", 32'({clk_out, tick, pending}), 32'd0);

        // Free run from reset: ticks on every 5th edge, clk_out toggling there.
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hF);
            checkOutput("tick_schedule", 32'(tick), (k % 5 == 0) ? 32'hF : 32'h0);
            if (k == 5)  checkOutput("clk_out_high", 32'(clk_out), 32'hF);
            if (k == 10) checkOutput("clk_out_low",  32'(clk_out), 32'h0);
        end

        // Mid-period divisor change on channel 1.
        applyStimulus(0, 0, 0, 0, 0, 4'hF);
        applyStimulus(0, 0, 0, 0, 0, 4'hF);
        applyStimulus(0, 0, 1, 2'd1, 8'd3, 4'hF);
        checkOutput("pending_after_write", 32'(pending), 32'h2);
        guard = 0;
        while (m_pend[1] && guard < 10) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hF);
            guard++;
        end
        checkOutput("ch1_applied_in_time", 32'(guard), 32'd2);
        checkOutput("ch1_pending_clear", 32'(pending[1]), 32'd0);
        hits = 0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hF);
            if (tick[1]) hits++;
        end
        checkOutput("ch1_ticks_div3", 32'(hits), 32'd3);

        // Divisor 0 and 1 both run at clk/2.
        applyStimulus(0, 0, 1, 2'd2, 8'd0, 4'hF);
        applyStimulus(0, 0, 1, 2'd3, 8'd1, 4'hF);
        for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 0, 0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hF);
            checkOutput("div01_tick_const", 32'(tick[3:2]), 32'h3);
        end

        // Channel 0 paused with a queued divisor: everything holds.
        applyStimulus(0, 0, 1, 2'd0, 8'd4, 4'hF);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hE);
            checkOutput("ch0_paused_tick", 32'(tick[0]), 32'd0);
            checkOutput("ch0_paused_pending", 32'(pending[0]), 32'd1);
        end
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 0, 0, 0, 4'hF);

        // Sync with a simultaneous write to channel 0.
        guard = 0;
        while (m_elapsed[0] != 3 && guard < 20) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hF);
            guard++;
        end
        checkOutput("ch0_reached_count3", 32'(m_elapsed[0]), 32'd3);
        applyStimulus(0, 1, 1, 2'd0, 8'd7, 4'hF);
        checkOutput("sync_outputs", 32'({clk_out, tick, pending}), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hF);
            checkOutput("ch0_tick_after_sync", 32'(tick[0]), (k == 7) ? 32'd1 : 32'd0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 200; k++) begin
            applyStimulus(0, ($urandom % 40) == 0, ($urandom % 6) == 0,
                          2'($urandom), 8'($urandom % 8), 4'($urandom));
        end

        // Reset mid-operation with every channel pending.
        for (int i = 0; i < NUM_CH; i++) applyStimulus(0, 0, 1, 2'(i), 8'(20 + i), 4'h0);
        checkOutput("all_pending", 32'(pending), 32'hF);
        applyStimulus(1, 0, 0, 0, 0, 4'hF);
        checkOutput("mid_reset_outputs", 32'({clk_out, tick, pending}), 32'd0);
        applyStimulus(1, 1, 1, 2'd2, 8'd9, 4'hF);
        checkOutput("reset_priority_outputs", 32'({clk_out, tick, pending}), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'hF);
            checkOutput("default_div_restored", 32'(tick), (k == 5) ? 32'hF : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
